// File: rtl/conv_window_reader.sv
// conv_window_reader: walks a row-major int4 feature map in RAM and streams every
// KxK stride-1 window to the conv engine, issuing one RAM read per cycle.
module conv_window_reader #(
   parameter int WIDTH    = 4,
   parameter int ADDR_BIT = 10,
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int K        = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_BIT-1:0]     img_base,
   output logic                    busy,
   output logic                    done,
   output logic                    ram_en,
   output logic [ADDR_BIT-1:0]     ram_addr,
   input  logic [WIDTH-1:0]        ram_dout,
   output logic [K*K*WIDTH-1:0]    win_data,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [15:0]             win_row,
   output logic [15:0]             win_col
);

   localparam int KK = K * K;
   localparam int IW = (KK > 1) ? $clog2(KK) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   localparam logic [ADDR_BIT-1:0] A_ONE    = ADDR_BIT'(1);
   localparam logic [ADDR_BIT-1:0] ROW_STEP = ADDR_BIT'(IMG_W - K + 1);
   localparam logic [ADDR_BIT-1:0] IMG_STEP = ADDR_BIT'(IMG_W);
   localparam logic [15:0]         LAST_COL = 16'(IMG_W - K);
   localparam logic [15:0]         LAST_ROW = 16'(IMG_H - K);
   localparam logic [KW-1:0]       K_LAST   = KW'(K - 1);
   localparam logic [KW-1:0]       K_ONE    = KW'(1);
   localparam logic [IW-1:0]       I_LAST   = IW'(KK - 1);
   localparam logic [IW-1:0]       I_ONE    = IW'(1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;

   logic [KW-1:0]         r_kr;
   logic [KW-1:0]         r_kc;
   logic [IW-1:0]         r_idx;
   logic [ADDR_BIT-1:0]   r_addr;
   logic [ADDR_BIT-1:0]   r_win_base;
   logic [ADDR_BIT-1:0]   r_row_base;
   logic [15:0]           r_row;
   logic [15:0]           r_col;
   logic                  r_cap_vld;
   logic [IW-1:0]         r_cap_idx;
   logic [KK*WIDTH-1:0]   r_win;

   logic                  w_fetch_last;
   logic                  w_last_col;
   logic                  w_last_win;

   assign w_fetch_last = (r_idx == I_LAST);
   assign w_last_col   = (r_col == LAST_COL);
   assign w_last_win   = w_last_col && (r_row == LAST_ROW);

   assign ram_addr = r_addr;
   assign win_data = r_win;
   assign win_row  = r_row;
   assign win_col  = r_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b0;
      done      = 1'b0;
      ram_en    = 1'b0;
      win_valid = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_FETCH;
         S_FETCH: begin
            busy   = 1'b1;
            ram_en = 1'b1;
            if (w_fetch_last) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy   = 1'b1;
            w_next = S_OUT;
         end
         S_OUT: begin
            busy      = 1'b1;
            win_valid = 1'b1;
            if (win_ready) w_next = w_last_win ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Read data returns one cycle after the address, so the slot index rides
   // one stage behind the fetch counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_vld <= 1'b0;
         r_cap_idx <= '0;
         r_win     <= '0;
      end else begin
         r_cap_vld <= (r_state == S_FETCH);
         r_cap_idx <= r_idx;
         for (int n = 0; n < KK; n++) begin
            if (r_cap_vld && (r_cap_idx == IW'(n))) r_win[n*WIDTH +: WIDTH] <= ram_dout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kr       <= '0;
         r_kc       <= '0;
         r_idx      <= '0;
         r_addr     <= '0;
         r_win_base <= '0;
         r_row_base <= '0;
         r_row      <= '0;
         r_col      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_addr     <= img_base;
               r_win_base <= img_base;
               r_row_base <= img_base;
               r_row      <= '0;
               r_col      <= '0;
               r_kr       <= '0;
               r_kc       <= '0;
               r_idx      <= '0;
            end
            S_FETCH: begin
               r_idx <= w_fetch_last ? '0 : r_idx + I_ONE;
               if (r_kc == K_LAST) begin
                  r_kc <= '0;
                  r_kr <= (r_kr == K_LAST) ? '0 : r_kr + K_ONE;
                  if (!w_fetch_last) r_addr <= r_addr + ROW_STEP;
               end else begin
                  r_kc   <= r_kc + K_ONE;
                  r_addr <= r_addr + A_ONE;
               end
            end
            // Window origin steps by 1 along a row and by IMG_W between rows;
            // all address math wraps modulo 2^ADDR_BIT.
            S_OUT: if (win_ready && !w_last_win) begin
               if (w_last_col) begin
                  r_col      <= '0;
                  r_row      <= r_row + 16'd1;
                  r_row_base <= r_row_base + IMG_STEP;
                  r_win_base <= r_row_base + IMG_STEP;
                  r_addr     <= r_row_base + IMG_STEP;
               end else begin
                  r_col      <= r_col + 16'd1;
                  r_win_base <= r_win_base + A_ONE;
                  r_addr     <= r_win_base + A_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader: 4x4 map with K=3 plus a 3x3 single-window instance,
// RAM holds addr mod 16; windows and read addresses are checked against queues.
module tb_conv_window_reader;

   localparam int WIDTH = 4;
   localparam int AB    = 10;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int K     = 3;
   localparam int DW    = K * K * WIDTH;

   typedef struct {
      logic [15:0]   row;
      logic [15:0]   col;
      logic [DW-1:0] data;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start, win_ready;
   logic [AB-1:0]   img_base;
   logic            busy, done, ram_en, win_valid;
   logic [AB-1:0]   ram_addr;
   logic [WIDTH-1:0] ram_dout = '0;
   logic [DW-1:0]   win_data;
   logic [15:0]     win_row, win_col;

   logic            start3, ready3;
   logic [AB-1:0]   img_base3;
   logic            busy3, done3, ram_en3, valid3;
   logic [AB-1:0]   addr3;
   logic [WIDTH-1:0] dout3 = '0;
   logic [DW-1:0]   data3;
   logic [15:0]     row3, col3;

   conv_window_reader #(.WIDTH(WIDTH), .ADDR_BIT(AB), .IMG_W(W), .IMG_H(H), .K(K)) u_dut (
      .clk(clk), .rst(rst), .start(start), .img_base(img_base), .busy(busy), .done(done),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout), .win_data(win_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col));

   conv_window_reader #(.WIDTH(WIDTH), .ADDR_BIT(AB), .IMG_W(3), .IMG_H(3), .K(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .img_base(img_base3), .busy(busy3), .done(done3),
      .ram_en(ram_en3), .ram_addr(addr3), .ram_dout(dout3), .win_data(data3),
      .win_valid(valid3), .win_ready(ready3), .win_row(row3), .win_col(col3));

   always @(posedge clk) if (ram_en)  ram_dout <= ram_addr[WIDTH-1:0];
   always @(posedge clk) if (ram_en3) dout3    <= addr3[WIDTH-1:0];

   int checks = 0, errors = 0;
   int hs_cnt = 0, done_cnt = 0, hs3 = 0, done3_cnt = 0;
   vec_t tbl[4];
   vec_t win_q[$];
   logic [AB-1:0] addr_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mdl_win(input int base, input int r, input int c);
      logic [DW-1:0] d;
      int a;
      d = '0;
      for (int kr = 0; kr < K; kr++)
         for (int kc = 0; kc < K; kc++) begin
            a = (base + (r + kr) * W + c + kc) % 1024;
            d[(kr*K+kc)*WIDTH +: WIDTH] = WIDTH'(a % 16);
         end
      return d;
   endfunction

   task automatic push_pass(input int base, input bit use_tbl);
      vec_t e;
      int n;
      n = 0;
      for (int r = 0; r <= H - K; r++)
         for (int c = 0; c <= W - K; c++) begin
            if (use_tbl) e = tbl[n];
            else begin
               e.row  = 16'(r);
               e.col  = 16'(c);
               e.data = mdl_win(base, r, c);
            end
            win_q.push_back(e);
            n++;
            for (int kr = 0; kr < K; kr++)
               for (int kc = 0; kc < K; kc++)
                  addr_q.push_back(AB'((base + (r + kr) * W + c + kc) % 1024));
         end
   endtask

   // Observes the values the next rising edge will see, then advances to the next falling edge.
   task automatic step();
      vec_t e;
      logic [AB-1:0] ea;
      if (!rst) begin
         if (ram_en) begin
            if (addr_q.size() == 0) chk("addr_extra_read", 64'(ram_addr), 64'hFFFF);
            else begin
               ea = addr_q.pop_front();
               chk("ram_addr", 64'(ram_addr), 64'(ea));
            end
         end
         if (win_valid && win_ready) begin
            if (win_q.size() == 0) chk("win_extra", 64'(win_data), 64'hFFFF_FFFF_FFFF);
            else begin
               e = win_q.pop_front();
               chk("win_data", 64'(win_data), 64'(e.data));
               chk("win_row", 64'(win_row), 64'(e.row));
               chk("win_col", 64'(win_col), 64'(e.col));
            end
            hs_cnt++;
         end
         if (done) done_cnt++;
         if (valid3 && ready3) begin
            chk("k3_data", 64'(data3), 64'h8_7654_3210);
            chk("k3_rowcol", 64'({row3, col3}), 64'd0);
            hs3++;
         end
         if (done3) done3_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic wait_done(input int bound);
      int i;
      i = 0;
      while (!done && i < bound) begin step(); i++; end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic wait_valid(input int bound);
      int i;
      i = 0;
      while (!win_valid && i < bound) begin step(); i++; end
      chk("valid_seen", 64'(win_valid), 64'd1);
   endtask

   initial begin
      int h0, d0, i;
      tbl[0] = '{16'd0, 16'd0, 36'hA98654210};
      tbl[1] = '{16'd0, 16'd1, 36'hBA9765321};
      tbl[2] = '{16'd1, 16'd0, 36'hEDCA98654};
      tbl[3] = '{16'd1, 16'd1, 36'hFEDBA9765};

      rst = 1'b1; start = 1'b0; win_ready = 1'b1; img_base = '0;
      start3 = 1'b0; ready3 = 1'b1; img_base3 = '0;
      step(); step();
      chk("rst_ctrl", 64'({busy, done, ram_en, win_valid}), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_data", 64'(win_data), 64'd0);
      chk("rst_rowcol", 64'({win_row, win_col}), 64'd0);
      rst = 1'b0;
      step();

      // Full pass with latency profile of the first window
      push_pass(0, 1'b1); h0 = hs_cnt; d0 = done_cnt;
      start = 1'b1; step(); start = 1'b0;
      chk("lat_busy", 64'(busy), 64'd1);
      for (int k = 0; k <= 10; k++) begin
         chk("lat_ram_en", 64'(ram_en), 64'(k <= 8));
         chk("lat_valid", 64'(win_valid), 64'(k == 10));
         if (k < 10) step();
      end
      wait_done(200);
      chk("p1_hs_before_done", 64'(hs_cnt - h0), 64'd4);
      step();
      chk("p1_done_cnt", 64'(done_cnt - d0), 64'd1);
      chk("p1_idle", 64'({busy, done}), 64'd0);
      chk("p1_queues", 64'(win_q.size() + addr_q.size()), 64'd0);

      // Consumer stall on window (0,1)
      push_pass(0, 1'b1); h0 = hs_cnt;
      win_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
      wait_valid(50);
      win_ready = 1'b1; step(); win_ready = 1'b0;
      wait_valid(50);
      for (int s = 0; s < 20; s++) begin
         step();
         chk("stall_valid", 64'(win_valid), 64'd1);
         chk("stall_data", 64'(win_data), 64'hBA9765321);
         chk("stall_ram_en", 64'(ram_en), 64'd0);
      end
      win_ready = 1'b1;
      wait_done(200);
      chk("p2_hs", 64'(hs_cnt - h0), 64'd4);
      step();

      // Base near top of address space: reads wrap modulo 1024
      push_pass(1020, 1'b0); h0 = hs_cnt;
      img_base = AB'(1020); start = 1'b1; step(); start = 1'b0; img_base = '0;
      wait_done(200);
      chk("p3_hs", 64'(hs_cnt - h0), 64'd4);
      step();
      chk("p3_queues", 64'(win_q.size() + addr_q.size()), 64'd0);

      // Reset during the 5th fetch cycle of window (1,0)
      push_pass(0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      i = 0;
      while (!(ram_en && win_row == 16'd1 && win_col == 16'd0) && i < 100) begin step(); i++; end
      chk("p5_reach_fetch", 64'({ram_en, win_row[0]}), 64'b11);
      repeat (4) step();
      chk("p5_in_fetch", 64'(ram_en), 64'd1);
      rst = 1'b1; #1;
      chk("p5_rst_ctrl", 64'({busy, done, ram_en, win_valid}), 64'd0);
      chk("p5_rst_addr", 64'(ram_addr), 64'd0);
      chk("p5_rst_data", 64'(win_data), 64'd0);
      chk("p5_rst_rowcol", 64'({win_row, win_col}), 64'd0);
      d0 = done_cnt;
      repeat (3) step();
      rst = 1'b0;
      win_q.delete(); addr_q.delete();
      step(); step();
      chk("p5_no_done", 64'(done_cnt - d0), 64'd0);
      chk("p5_idle", 64'(busy), 64'd0);
      push_pass(0, 1'b1); h0 = hs_cnt;
      start = 1'b1; step(); start = 1'b0;
      wait_done(200);
      chk("p5_restart_hs", 64'(hs_cnt - h0), 64'd4);
      step();

      // start pulses while busy, including during the DONE cycle
      push_pass(0, 1'b1); h0 = hs_cnt; d0 = done_cnt;
      start = 1'b1; step(); start = 1'b0;
      repeat (3) step();
      start = 1'b1; step(); start = 1'b0;
      wait_valid(50);
      start = 1'b1; step(); start = 1'b0;
      wait_done(200);
      start = 1'b1; step(); start = 1'b0;
      chk("p6_busy_after_done", 64'(busy), 64'd0);
      for (int s = 0; s < 3; s++) begin
         step();
         chk("p6_quiet", 64'({busy, ram_en}), 64'd0);
      end
      chk("p6_hs", 64'(hs_cnt - h0), 64'd4);
      chk("p6_done_cnt", 64'(done_cnt - d0), 64'd1);
      chk("p6_queues", 64'(win_q.size() + addr_q.size()), 64'd0);

      // K == IMG_W == IMG_H: a single window
      start3 = 1'b1; step(); start3 = 1'b0;
      i = 0;
      while (!done3 && i < 50) begin step(); i++; end
      chk("k3_done_seen", 64'(done3), 64'd1);
      chk("k3_hs", 64'(hs3), 64'd1);
      step();
      chk("k3_idle", 64'(busy3), 64'd0);
      chk("k3_done_cnt", 64'(done3_cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read-side initiator for the int4 feature-map dual-port RAM.
- Walks a row-major IMG_W x IMG_H map stored from a base address.
- Drives one RAM port (en/addr, 1-cycle read latency).
- Assembles each KxK valid-convolution window (stride 1, no padding) and streams it to the conv engine with a valid/ready handshake.

Parameters:
WIDTH, 4, element bit width (int4)
ADDR_BIT, 10, RAM address width
IMG_W, 28, map width in elements
IMG_H, 28, map height in elements
K, 3, window size; K <= IMG_W and K <= IMG_H

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pass over the map when idle
img_base  in  ADDR_BIT  map base address, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last window handshake
ram_en  out  1  RAM port enable (read only; this block never writes)
ram_addr  out  ADDR_BIT  RAM read address
ram_dout  in  WIDTH  RAM read data, valid the cycle after ram_en
win_data  out  K*K*WIDTH  packed window; element (kr,kc) at bits [(kr*K+kc)*WIDTH +: WIDTH]
win_valid  out  1  window available
win_ready  in  1  consumer accepts window
win_row  out  16  output row index of the current window
win_col  out  16  output column index of the current window

Behaviour:
- Reset (async, any state): FSM to IDLE; busy, done, ram_en, win_valid = 0; ram_addr, win_data, win_row, win_col = 0; all counters = 0.
- FSM states:
  - IDLE: start=1 latches img_base, row=col=0, then goes to FETCH.
  - FETCH: K*K cycles, one read per cycle, ram_en=1. Address = img_base + (row+kr)*IMG_W + (col+kc), kc fastest. Arithmetic is modulo 2^ADDR_BIT, so addresses wrap silently. Addresses are computed incrementally (+1 within a kernel row; +IMG_W-K+1 between kernel rows); no multiplier.
  - DRAIN: one cycle, ram_en=0; the last element is captured.
  - OUT: win_valid=1. win_data, win_row and win_col hold stable until win_valid & win_ready.
  - On handshake: advance col. At col = IMG_W-K, wrap col to 0 and increment row. If the window just accepted was (IMG_H-K, IMG_W-K), go to DONE; otherwise go to FETCH.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Capture: element n is written into the win_data slot n one cycle after its address is issued. The capture pipeline tracks slot index alongside the read.
- Latency:
  - ram_en/first address appear the cycle after start is sampled.
  - win_valid rises 11 clk edges after the start edge (K=3).
  - With win_ready held high, one window is produced per K*K+2 cycles.
- Boundary conditions:
  - start while busy: ignored, including start during the DONE cycle.
  - win_ready while win_valid=0: ignored.
  - win_ready held low: the block stalls indefinitely in OUT with no RAM activity.
  - Window count per pass: (IMG_W-K+1)*(IMG_H-K+1).
  - K == IMG_W == IMG_H: exactly one window, then done.
  - rst mid-FETCH or mid-OUT: immediate return to IDLE; the partial window is discarded and no done pulse is issued.
- The RAM's other port may be written concurrently by the producer; this block gives no coherency guarantee.

Test Plan:
1. IMG_W=IMG_H=4, K=3, RAM[a]=a mod 16, img_base=0, start, win_ready=1.
   - Windows arrive in order (0,0),(0,1),(1,0),(1,1).
   - First window is 36'hA98654210; last window is 36'hFEDBA9765.
   - done pulses once, after the 4th handshake; busy is then 0.
2. Same setup, win_ready low for 20 cycles on window (0,1).
   - win_valid and win_data stay constant (36'hBA9765321); ram_en stays 0 during the stall.
   - The next window (1,0) follows normally.
3. img_base=1020, IMG_W=IMG_H=4.
   - First read addresses are 1020,1021,1022, then 0,1,2, then 4,5,6 (wrap modulo 1024).
4. Latency check.
   - start sampled at edge 0: ram_addr valid at edges 1..9, win_valid rises at edge 11, exactly 9 ram_en cycles per window.
5. Assert rst during the 5th FETCH cycle of window (1,0).
   - All outputs go to 0 immediately; no done pulse.
   - A new start restarts at window (0,0) with correct data.
6. start pulsed while busy.
   - No effect: window order and count are unchanged.
   - Case IMG_W=IMG_H=K=3: exactly one window, then done.
